// File: rtl/sram_rr_arbiter_if.sv
// Requester-side bus of the SRAM round-robin arbiter.
//   req_valid/req_ready : per-requester handshake, bit i = requester i
//   req_we              : 1 = write, 0 = read, per requester
//   req_addr/req_wdata  : requester i fields at [i*AW +: AW] / [i*DW +: DW]
//   rsp_valid/rsp_data  : one-cycle read-response pulse tagged per requester
// Modports: master = requester side, slave = arbiter side.
interface sram_rr_arbiter_if #(
  parameter int AW = 1,
  parameter int DW = 1
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter/controller for a single-port sync SRAM
// (registered write, combinational read). After reset it clears every entry,
// then grants one read or write per cycle. Read data returns one cycle after
// the grant, tagged with the requester that issued it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester handshake/response interface (slave side)
//   sram_we/wa/wd : SRAM write port
//   sram_ra/rq    : SRAM read address / combinational read data
module sram_rr_arbiter #(
  parameter int AW = 1,
  parameter int DW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_rr_arbiter_if.slave bus,
  output logic             sram_we,
  output logic [AW-1:0]    sram_wa,
  output logic [DW-1:0]    sram_wd,
  output logic [AW-1:0]    sram_ra,
  input  logic [DW-1:0]    sram_rq
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [AW-1:0] init_cnt;
  logic          last;

  logic          gnt_any;
  logic          gnt_idx;
  logic          gnt_we;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;

  // Grant: a lone requester wins; under contention the one not served last wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    if (state == RUN) begin
      gnt_any = |bus.req_valid;
      gnt_idx = (&bus.req_valid) ? ~last : bus.req_valid[1];
    end
    gnt_we    = gnt_idx ? bus.req_we[1] : bus.req_we[0];
    gnt_addr  = gnt_idx ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
    gnt_wdata = gnt_idx ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
    bus.req_ready = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  // SRAM pins; held quiet while reset is asserted even though state reads INIT.
  always_comb begin
    sram_we = 1'b0;
    sram_wa = '0;
    sram_wd = '0;
    sram_ra = '0;
    if (rst_n) begin
      if (state == INIT) begin
        sram_we = 1'b1;
        sram_wa = init_cnt;
      end else if (gnt_any) begin
        if (gnt_we) begin
          sram_we = 1'b1;
          sram_wa = gnt_addr;
          sram_wd = gnt_wdata;
        end else begin
          sram_ra = gnt_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      init_cnt      <= '0;
      last          <= 1'b1;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else begin
      case (state)
        INIT: begin
          bus.rsp_valid <= '0;
          init_cnt      <= init_cnt + 1'b1;
          if (init_cnt == '1) state <= RUN;
        end
        RUN: begin
          if (gnt_any) begin
            last <= gnt_idx;
            if (gnt_we) begin
              bus.rsp_valid <= '0;
            end else begin
              bus.rsp_valid <= gnt_idx ? 2'b10 : 2'b01;
              bus.rsp_data  <= sram_rq;
            end
          end else begin
            bus.rsp_valid <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter (AW=1, DW=1): directed scenarios
// plus randomized traffic, compared against a behavioural memory/arbitration
// model held in the bench. Includes a small SRAM model on the DUT's SRAM pins.
module tb_sram_rr_arbiter;
  localparam int AW    = 1;
  localparam int DW    = 1;
  localparam int DEPTH = 2 ** AW;

  logic clk;
  logic rst_n;
  logic          sram_we;
  logic [AW-1:0] sram_wa;
  logic [DW-1:0] sram_wd;
  logic [AW-1:0] sram_ra;
  logic [DW-1:0] sram_rq;

  int n_tests;
  int n_fail;

  sram_rr_arbiter_if #(.AW(AW), .DW(DW)) rif ();

  sram_rr_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (rif.slave),
    .sram_we (sram_we),
    .sram_wa (sram_wa),
    .sram_wd (sram_wd),
    .sram_ra (sram_ra),
    .sram_rq (sram_rq)
  );

  // SRAM: registered write, combinational read.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) if (sram_we) sram_mem[sram_wa] <= sram_wd;
  assign sram_rq = sram_mem[sram_ra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory contents, who was served most recently,
  // clear progress and the response expected in the current cycle.
  logic          m_init;
  int            m_cnt;
  int            m_last;
  logic [DW-1:0] m_mem [DEPTH];
  logic [1:0]    m_rsp_v;
  logic [DW-1:0] m_rsp_d;
  logic [1:0]    m_gnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init  = 1'b1;
    m_cnt   = 0;
    m_last  = 1;
    m_rsp_v = 2'b00;
    m_rsp_d = '0;
    m_gnt   = 2'b00;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // Drive one cycle of requests, check everything, advance the model at the edge.
  task automatic do_cycle(input logic [1:0] v, input logic [1:0] we,
                          input logic [1:0] a, input logic [1:0] d);
    int   w;
    logic has;
    rif.req_valid = v;
    rif.req_we    = we;
    rif.req_addr  = a;
    rif.req_wdata = d;
    #2;
    check("rsp_valid", {30'd0, rif.rsp_valid}, {30'd0, m_rsp_v});
    check("rsp_data", {31'd0, rif.rsp_data}, {31'd0, m_rsp_d});
    has = 1'b0;
    w   = 0;
    if (m_init) begin
      check("init_ready", {30'd0, rif.req_ready}, 32'd0);
      check("init_we", {31'd0, sram_we}, 32'd1);
      check("init_wa", {31'd0, sram_wa}, m_cnt);
      check("init_wd", {31'd0, sram_wd}, 32'd0);
    end else begin
      if (v != 2'b00) begin
        has = 1'b1;
        if (v == 2'b11) w = 1 - m_last;
        else            w = v[1] ? 1 : 0;
      end
      check("ready", {30'd0, rif.req_ready}, has ? (32'd1 << w) : 32'd0);
      if (has && we[w]) begin
        check("wr_we", {31'd0, sram_we}, 32'd1);
        check("wr_wa", {31'd0, sram_wa}, {31'd0, a[w]});
        check("wr_wd", {31'd0, sram_wd}, {31'd0, d[w]});
      end else begin
        check("idle_we", {31'd0, sram_we}, 32'd0);
        if (has) check("rd_ra", {31'd0, sram_ra}, {31'd0, a[w]});
        else     check("idle_ra", {31'd0, sram_ra}, 32'd0);
      end
    end
    @(posedge clk);
    m_gnt = 2'b00;
    if (m_init) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_init = 1'b0;
      m_rsp_v = 2'b00;
    end else if (has) begin
      m_gnt  = 2'(1 << w);
      m_last = w;
      if (we[w]) begin
        m_mem[a[w]] = d[w];
        m_rsp_v = 2'b00;
      end else begin
        m_rsp_v = 2'(1 << w);
        m_rsp_d = m_mem[a[w]];
      end
    end else begin
      m_rsp_v = 2'b00;
    end
    @(negedge clk);
  endtask

  logic [1:0] cv, cwe, ca, cd;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    rif.req_valid = '0;
    rif.req_we    = '0;
    rif.req_addr  = '0;
    rif.req_wdata = '0;
    model_reset();
    #3;
    check("rst_ready", {30'd0, rif.req_ready}, 32'd0);
    check("rst_sram_we", {31'd0, sram_we}, 32'd0);
    check("rst_rsp_valid", {30'd0, rif.rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clear phase, then an immediate grant to requester 0.
    do_cycle(2'b01, 2'b00, 2'b00, 2'b00);
    do_cycle(2'b01, 2'b00, 2'b00, 2'b00);
    do_cycle(2'b01, 2'b00, 2'b00, 2'b00);

    // Req0 writes addr1=1, then reads it back.
    do_cycle(2'b01, 2'b01, 2'b01, 2'b01);
    do_cycle(2'b01, 2'b00, 2'b01, 2'b00);
    #2 check("wr_rd_rsp", {29'd0, rif.rsp_valid, rif.rsp_data}, 32'b011);

    // Req1 alone: write addr0=1, read addr0, read addr1.
    do_cycle(2'b10, 2'b10, 2'b00, 2'b10);
    do_cycle(2'b10, 2'b00, 2'b00, 2'b00);
    do_cycle(2'b10, 2'b00, 2'b10, 2'b00);

    // Contention: both reading for 4 cycles alternates 0,1,0,1.
    for (int i = 0; i < 4; i++) do_cycle(2'b11, 2'b00, 2'b01, 2'b00);
    do_cycle(2'b00, 2'b00, 2'b00, 2'b00);

    // Cross-requester visibility: req1 writes addr0=1, req0 reads addr0.
    do_cycle(2'b10, 2'b10, 2'b00, 2'b10);
    do_cycle(2'b01, 2'b00, 2'b00, 2'b00);
    #2 check("cross_rsp", {29'd0, rif.rsp_valid, rif.rsp_data}, 32'b011);
    do_cycle(2'b00, 2'b00, 2'b00, 2'b00);

    // Randomized traffic; a requester left waiting keeps its request stable.
    cv = '0; cwe = '0; ca = '0; cd = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(cv[i] && !m_gnt[i])) begin
          cv[i]  = ($urandom_range(0, 3) != 0);
          cwe[i] = $urandom_range(0, 1) != 0;
          ca[i]  = $urandom_range(0, 1) != 0;
          cd[i]  = $urandom_range(0, 1) != 0;
        end
      end
      do_cycle(cv, cwe, ca, cd);
    end

    // Reset mid-operation: write addr0=1, read it, reset as the response lands.
    do_cycle(2'b10, 2'b10, 2'b00, 2'b10);
    do_cycle(2'b01, 2'b00, 2'b00, 2'b00);
    rif.req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", {30'd0, rif.rsp_valid}, 32'd0);
    check("midrst_sram_we", {31'd0, sram_we}, 32'd0);
    check("midrst_ready", {30'd0, rif.req_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(2'b00, 2'b00, 2'b00, 2'b00);
    do_cycle(2'b00, 2'b00, 2'b00, 2'b00);
    do_cycle(2'b01, 2'b00, 2'b00, 2'b00);
    #2 check("post_rst_rsp", {29'd0, rif.rsp_valid, rif.rsp_data}, 32'b010);
    do_cycle(2'b00, 2'b00, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
